// File: rtl/vx_amo_arb.sv
// Round-robin front end for a shared AMO unit port. Outstanding requests are
// counted; an AMO waits for the count to drain, then blocks all grants until its response returns.
module vx_amo_arb #(
    parameter int NUM_REQS      = 4,
    parameter int REQ_SEL_WIDTH = $clog2(NUM_REQS),
    parameter int PAYLOAD_WIDTH = 128,
    parameter int RSP_WIDTH     = 48,
    parameter int MAX_PENDING   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               in_req_valid,
    input  logic [NUM_REQS-1:0]               in_req_amo,
    input  logic [NUM_REQS*PAYLOAD_WIDTH-1:0] in_req_payload,
    output logic [NUM_REQS-1:0]               in_req_ready,
    output logic                              out_req_valid,
    output logic [PAYLOAD_WIDTH-1:0]          out_req_payload,
    output logic [REQ_SEL_WIDTH-1:0]          out_req_idx,
    input  logic                              out_req_ready,
    input  logic                              out_rsp_valid,
    input  logic [RSP_WIDTH-1:0]              out_rsp_payload,
    input  logic [REQ_SEL_WIDTH-1:0]          out_rsp_idx,
    output logic                              out_rsp_ready,
    output logic [NUM_REQS-1:0]               in_rsp_valid,
    output logic [RSP_WIDTH-1:0]              in_rsp_payload,
    input  logic [NUM_REQS-1:0]               in_rsp_ready,
    output logic                              busy
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_AMO_WAIT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [REQ_SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_SEL_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic [PEND_W-1:0]        pending_q, pending_d;

    logic                     win_found;
    logic [REQ_SEL_WIDTH-1:0] win_idx;
    logic [REQ_SEL_WIDTH-1:0] sel_idx;
    logic                     issue;
    logic                     accept;
    logic                     rsp_fire;

    logic [PAYLOAD_WIDTH-1:0] req_payload [NUM_REQS];

    // Index arithmetic modulo NUM_REQS; base and offset are both below NUM_REQS.
    function automatic logic [REQ_SEL_WIDTH-1:0] wrap_add(
        input logic [REQ_SEL_WIDTH-1:0] base,
        input int                       off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQS) begin
            s = s - NUM_REQS;
        end
        return REQ_SEL_WIDTH'(s);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
            assign req_payload[gi]  = in_req_payload[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            assign in_req_ready[gi] = accept && (sel_idx == REQ_SEL_WIDTH'(gi));
            assign in_rsp_valid[gi] = out_rsp_valid && (out_rsp_idx == REQ_SEL_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!win_found && in_req_valid[wrap_add(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // While draining, the locked AMO owns the port regardless of the pointer.
    assign sel_idx = (state_q == ST_DRAIN) ? lock_idx_q : win_idx;

    always_comb begin
        issue = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (win_found) begin
                    if (!in_req_amo[win_idx]) begin
                        issue = (pending_q < PEND_MAX);
                    end else begin
                        issue = (pending_q == '0);
                    end
                end
            end
            ST_DRAIN: begin
                issue = in_req_valid[lock_idx_q] && (pending_q == '0);
            end
            default: issue = 1'b0;
        endcase
    end

    assign accept   = issue && out_req_ready;
    assign rsp_fire = out_rsp_valid && out_rsp_ready;

    always_comb begin
        pending_d = pending_q;
        if (accept && !rsp_fire) begin
            pending_d = pending_q + 1'b1;
        end else if (!accept && rsp_fire && (pending_q != '0)) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            rr_ptr_d = wrap_add(sel_idx, 1);
        end
        case (state_q)
            ST_ARB: begin
                if (win_found && in_req_amo[win_idx]) begin
                    if (pending_q != '0) begin
                        state_d    = ST_DRAIN;
                        lock_idx_d = win_idx;
                    end else if (out_req_ready) begin
                        state_d    = ST_AMO_WAIT;
                        lock_idx_d = win_idx;
                    end
                end
            end
            ST_DRAIN: begin
                if (!in_req_valid[lock_idx_q]) begin
                    state_d = ST_ARB;
                end else if (accept) begin
                    state_d = ST_AMO_WAIT;
                end
            end
            ST_AMO_WAIT: begin
                if (rsp_fire && (out_rsp_idx == lock_idx_q) && (pending_d == '0)) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        out_rsp_ready = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (out_rsp_idx == REQ_SEL_WIDTH'(k)) begin
                out_rsp_ready = in_rsp_ready[k];
            end
        end
    end

    assign out_req_valid   = issue;
    assign out_req_payload = issue ? req_payload[sel_idx] : '0;
    assign out_req_idx     = issue ? sel_idx : '0;
    assign in_rsp_payload  = out_rsp_payload;
    assign busy            = (pending_q != '0) || (state_q != ST_ARB);

endmodule

// File: tb/tb_vx_amo_arb.sv
// Directed vector bench for vx_amo_arb: one vector per cycle, inputs driven at
// the falling edge and combinational outputs compared 1ns later.
module tb_vx_amo_arb;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   in_req_valid = '0;
    logic [3:0]   in_req_amo = '0;
    logic [511:0] in_req_payload;
    logic [3:0]   in_req_ready;
    logic         out_req_valid;
    logic [127:0] out_req_payload;
    logic [1:0]   out_req_idx;
    logic         out_req_ready = 1'b0;
    logic         out_rsp_valid = 1'b0;
    logic [47:0]  out_rsp_payload = '0;
    logic [1:0]   out_rsp_idx = '0;
    logic         out_rsp_ready;
    logic [3:0]   in_rsp_valid;
    logic [47:0]  in_rsp_payload;
    logic [3:0]   in_rsp_ready = '0;
    logic         busy;

    vx_amo_arb dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_amo(in_req_amo),
        .in_req_payload(in_req_payload), .in_req_ready(in_req_ready),
        .out_req_valid(out_req_valid), .out_req_payload(out_req_payload),
        .out_req_idx(out_req_idx), .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_payload(out_rsp_payload),
        .out_rsp_idx(out_rsp_idx), .out_rsp_ready(out_rsp_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_payload(in_rsp_payload),
        .in_rsp_ready(in_rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [3:0] a;
        logic       ordy;
        logic       rspv;
        logic [1:0] ridx;
        logic [3:0] irdy;
        logic       e_ov;
        logic [1:0] e_idx;
        logic [3:0] e_ir;
        logic       e_busy;
    } vec_t;

    vec_t vecs [100];
    int   nv = 0;
    int   vec_no = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic logic [127:0] pay_of(input int i);
        return {32'hCAFE_0000 + 32'(i), 32'h1234_0000 ^ 32'(i * 7), 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic vec_t mk(input int v, input int a, input int ordy, input int rspv,
                                input int ridx, input int irdy, input int e_ov,
                                input int e_idx, input int e_ir, input int e_busy);
        vec_t t;
        t.v = 4'(v); t.a = 4'(a); t.ordy = 1'(ordy); t.rspv = 1'(rspv);
        t.ridx = 2'(ridx); t.irdy = 4'(irdy); t.e_ov = 1'(e_ov);
        t.e_idx = 2'(e_idx); t.e_ir = 4'(e_ir); t.e_busy = 1'(e_busy);
        return t;
    endfunction

    task automatic add(input vec_t t);
        vecs[nv] = t;
        nv++;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, vec_no, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        logic [127:0] e_pay;
        logic [3:0]   e_irv;
        logic [47:0]  rpay;
        @(negedge clk);
        rpay            = {16'hBEEF, 32'(vec_no)};
        in_req_valid    = t.v;
        in_req_amo      = t.a;
        out_req_ready   = t.ordy;
        out_rsp_valid   = t.rspv;
        out_rsp_idx     = t.ridx;
        in_rsp_ready    = t.irdy;
        out_rsp_payload = rpay;
        #1;
        e_pay = t.e_ov ? pay_of(int'(t.e_idx)) : '0;
        e_irv = t.rspv ? (4'b0001 << t.ridx) : 4'b0000;
        chk("out_req_valid", 128'(out_req_valid), 128'(t.e_ov));
        chk("out_req_idx", 128'(out_req_idx), 128'(t.e_ov ? t.e_idx : 2'd0));
        chk("in_req_ready", 128'(in_req_ready), 128'(t.e_ir));
        chk("out_req_payload", out_req_payload, e_pay);
        chk("out_rsp_ready", 128'(out_rsp_ready), 128'(t.irdy[t.ridx]));
        chk("in_rsp_valid", 128'(in_rsp_valid), 128'(e_irv));
        chk("in_rsp_payload", 128'(in_rsp_payload), 128'(rpay));
        chk("busy", 128'(busy), 128'(t.e_busy));
        $display("vec %0d: v=%h amo=%h rsp=%0d/%0d -> ov=%0d idx=%0d rdy=%h busy=%0d",
                 vec_no, t.v, t.a, t.rspv, t.ridx, out_req_valid, out_req_idx,
                 in_req_ready, busy);
        vec_no++;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_req_payload[i*128 +: 128] = pay_of(i);
        end

        // args: valid, amo, out_req_ready, rsp_valid, rsp_idx, in_rsp_ready,
        //       exp out_req_valid, exp idx, exp in_req_ready, exp busy
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // round robin up to the credit limit, then one response frees one credit
        add(mk(15, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        add(mk(15, 0, 1, 0, 0, 0, 1, 1, 2, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 2, 4, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 3, 8, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 1, 2, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 2, 4, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 3, 8, 1));
        add(mk(15, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        add(mk(15, 0, 1, 1, 0, 15, 0, 0, 0, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        for (int i = 0; i < 8; i++) add(mk(0, 0, 0, 1, 1, 15, 0, 0, 0, 1));
        // simultaneous accept and response keeps the count: stall after exactly 8
        add(mk(15, 0, 1, 0, 0, 0, 1, 1, 2, 0));
        add(mk(15, 0, 1, 0, 0, 0, 1, 2, 4, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 3, 8, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        add(mk(15, 0, 1, 1, 2, 15, 1, 1, 2, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 2, 4, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 3, 8, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 1, 2, 1));
        add(mk(15, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 8; i++) add(mk(0, 0, 0, 1, 1, 15, 0, 0, 0, 1));
        // three loads outstanding, then AMO from requester 2 drains and locks
        add(mk(11, 0, 1, 0, 0, 0, 1, 3, 8, 0));
        add(mk(11, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        add(mk(11, 0, 1, 0, 0, 0, 1, 1, 2, 1));
        add(mk(15, 4, 1, 0, 0, 0, 0, 0, 0, 1));
        add(mk(15, 4, 1, 1, 0, 15, 0, 0, 0, 1));
        add(mk(15, 4, 1, 1, 1, 15, 0, 0, 0, 1));
        add(mk(15, 4, 1, 1, 3, 15, 0, 0, 0, 1));
        add(mk(15, 4, 1, 0, 0, 0, 1, 2, 4, 1));
        add(mk(15, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        add(mk(15, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        add(mk(15, 0, 1, 1, 2, 4, 0, 0, 0, 1));
        add(mk(11, 0, 1, 0, 0, 0, 1, 3, 8, 0));
        add(mk(0, 0, 0, 1, 3, 15, 0, 0, 0, 1));
        // immediate AMO from requester 1; requester 2 is next after its response
        add(mk(2, 2, 1, 0, 0, 0, 1, 1, 2, 0));
        add(mk(15, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        add(mk(15, 0, 1, 1, 1, 2, 0, 0, 0, 1));
        add(mk(15, 0, 1, 0, 0, 0, 1, 2, 4, 0));
        add(mk(0, 0, 0, 1, 2, 15, 0, 0, 0, 1));
        // AMO presented while the unit is not ready, then accepted
        add(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        add(mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 0));
        add(mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 1));
        // response routing with the target not ready; handshake at zero count
        add(mk(0, 0, 0, 1, 3, 7, 0, 0, 0, 0));
        add(mk(0, 0, 0, 1, 3, 7, 0, 0, 0, 0));
        add(mk(0, 0, 0, 1, 3, 15, 0, 0, 0, 0));
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            run_vec(vecs[i]);
        end

        // locked requester withdraws while draining: back to normal arbitration
        run_vec(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 0));
        run_vec(mk(3, 2, 1, 0, 0, 0, 0, 0, 0, 1));
        run_vec(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        run_vec(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        run_vec(mk(0, 0, 0, 1, 0, 15, 0, 0, 0, 1));
        run_vec(mk(0, 0, 0, 1, 0, 15, 0, 0, 0, 1));
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset while an AMO is in flight clears the lock and the pointer
        run_vec(mk(4, 4, 1, 0, 0, 0, 1, 2, 4, 0));
        @(negedge clk);
        reset         = 1'b1;
        in_req_valid  = '0;
        in_req_amo    = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        in_rsp_ready  = '0;
        @(negedge clk);
        reset = 1'b0;
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(10, 0, 1, 0, 0, 0, 1, 1, 2, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
